j_sinerom_arb: RTL and testbench
================================

Name: j_sinerom_arb

Overview:
- Arbitrates the DSP wavetable (sine) ROM between two requesters: the DSP core read path and the host/debug bus read path.
- Sequences ROM enable and address, tracks in-flight reads through a fixed-latency pipeline, and returns each result to its owner with a one-cycle ack.
- Returned data is sign-extended from bit 15 to 32 bits.
- Sits between the DSP load unit, the bus slave and the 1024x16 ROM macro.

Parameters:
- ROM_LAT, 1, cycles from the rom_en/rom_a cycle to rom_q valid (1..4).
- SIGNX, 1, 1 = data[31:16] replicate rom_q[15]; 0 = zero-fill.

Ports:
- sys_clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous reset, active-high.
- dsp_req  in  1  DSP read request; held with dsp_addr stable until dsp_ack.
- dsp_addr  in  10  DSP ROM word address.
- dsp_ack  out  1  one-cycle pulse; dsp_data valid this cycle.
- dsp_data  out  32  DSP read result.
- host_req  in  1  host read request; same rules as dsp_req.
- host_addr  in  10  host ROM word address.
- host_ack  out  1  one-cycle pulse; host_data valid this cycle.
- host_data  out  32  host read result.
- rom_en  out  1  ROM access strobe; this is the ROM chip select, active-high.
- rom_a  out  10  ROM address, valid when rom_en=1.
- rom_q  in  16  ROM data, valid ROM_LAT cycles after rom_en.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset values: rom_en=0, rom_a=0, dsp_ack=0, host_ack=0, dsp_data=0, host_data=0, busy=0, rr pointer=DSP.
- Reset asserted mid-operation clears all in-flight tags. No ack is produced for discarded reads.
- Eligibility: a requester is eligible when its req=1, it has no read in flight, and its ack is not asserted this cycle.
- Each requester has at most one read outstanding.
- Issue: each cycle, at most one eligible requester is granted.
  - Grant is combinational from the registered state.
  - rom_en and rom_a are registered: they assert the cycle after the grant decision, which is the issue cycle.
- Arbitration: round-robin.
  - When both requesters are eligible, grant the one named by the rr pointer, then point rr at the other.
  - A single eligible requester is granted without changing rr.
- Tag pipeline: ROM_LAT+1 stages of {valid, owner}.
  - A tag entered at grant reaches the output stage when rom_q is valid.
  - In that cycle, register rom_q into the owner's data register, extended per SIGNX.
  - The owner's ack pulses on the following cycle.
  - Total latency from req sampled (eligible, granted) to ack = ROM_LAT+2 cycles. For ROM_LAT=1 this is 3 cycles.
- Throughput: back-to-back issues to alternating owners are allowed every cycle. The pipeline never stalls, because the ROM has no wait states.
- A requester re-asserting req in the same cycle as its ack is not eligible that cycle. It becomes eligible the next cycle.
- The other requester's data register holds its value when that requester is not acked.
- Dropping req before ack does not cancel the read. The ack is still produced.
- busy is 1 while any tag valid bit is set.
- Address range is 0..1023. No wrap or aliasing logic is required.

Test Plan:
- Reset → all outputs 0.
  - Then dsp_req=1, dsp_addr=0x100 with rom_q model returning 0x7FFF.
  - dsp_ack pulses exactly 3 cycles later (ROM_LAT=1) with dsp_data=0x00007FFF.
- Sign extension with host_addr=0x200 and rom_q=0x8001:
  - SIGNX=1 → host_data=0xFFFF8001.
  - SIGNX=0 → host_data=0x00008001.
- Both requesters asserted continuously from reset:
  - Grants alternate DSP, host, DSP, host…; DSP is first.
  - rom_a alternates between the two addresses.
  - Each ack is matched to the correct address data; no lost or duplicated ack over 100 reads.
- Single requester with req held continuously:
  - One read per 4 cycles (issue blocked while in flight, plus the ack cycle).
  - rr unchanged when the other requester later arrives; DSP still wins the first tie.
- Reset pulsed one cycle after a DSP issue:
  - No dsp_ack occurs.
  - busy=0 immediately.
  - The next request completes normally.
- ROM_LAT=3 sweep with random req timing:
  - Ack latency = 5 cycles for every read.
  - Scoreboard matches data to address for both owners.

Source files
------------

// File: rtl/j_sinerom_arb.sv
`default_nettype none
// ============================================================================
// Module : j_sinerom_arb
// Round-robin arbiter sharing the 1024x16 sine ROM between the DSP and host
// read ports, with a fixed-latency tag pipeline steering data back to owners.
// Rev    : 1.0  initial release
// ============================================================================
module j_sinerom_arb #(
  parameter int ROM_LAT = 1,
  parameter bit SIGNX   = 1'b1
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        dsp_req,
  input  logic [9:0]  dsp_addr,
  output logic        dsp_ack,
  output logic [31:0] dsp_data,
  input  logic        host_req,
  input  logic [9:0]  host_addr,
  output logic        host_ack,
  output logic [31:0] host_data,
  output logic        rom_en,
  output logic [9:0]  rom_a,
  input  logic [15:0] rom_q,
  output logic        busy
);

  localparam int NSTG = ROM_LAT + 1;

  typedef enum logic {
    OWN_DSP  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  owner_e          rr_q, rr_d;
  logic            rom_en_q, rom_en_d;
  logic [9:0]      rom_a_q, rom_a_d;
  logic [NSTG-1:0] tag_vld_q, tag_vld_d;
  logic [NSTG-1:0] tag_host_q, tag_host_d;
  logic            dsp_ack_q, dsp_ack_d;
  logic            host_ack_q, host_ack_d;
  logic [31:0]     dsp_data_q, dsp_data_d;
  logic [31:0]     host_data_q, host_data_d;

  logic            w_dsp_inflt, w_host_inflt;
  logic            w_dsp_elig, w_host_elig;
  logic            w_gnt_vld, w_gnt_host;
  logic            w_out_vld, w_out_host;
  logic [31:0]     w_rom_ext;

  // Tag owner bit: 1 = host, 0 = DSP.
  assign w_dsp_inflt  = |(tag_vld_q & ~tag_host_q);
  assign w_host_inflt = |(tag_vld_q &  tag_host_q);

  assign w_dsp_elig   = dsp_req  & ~w_dsp_inflt  & ~dsp_ack_q;
  assign w_host_elig  = host_req & ~w_host_inflt & ~host_ack_q;

  assign w_out_vld    = tag_vld_q[ROM_LAT];
  assign w_out_host   = tag_host_q[ROM_LAT];

  generate
    if (SIGNX) begin : g_signx
      assign w_rom_ext = {{16{rom_q[15]}}, rom_q};
    end else begin : g_zero
      assign w_rom_ext = {16'h0000, rom_q};
    end
  endgenerate

  // Grant decision; rr only moves when both sides contend.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_host = 1'b0;
    rr_d       = rr_q;
    if (w_dsp_elig && w_host_elig) begin
      w_gnt_vld  = 1'b1;
      w_gnt_host = (rr_q == OWN_HOST);
      rr_d       = (rr_q == OWN_HOST) ? OWN_DSP : OWN_HOST;
    end else if (w_dsp_elig) begin
      w_gnt_vld  = 1'b1;
    end else if (w_host_elig) begin
      w_gnt_vld  = 1'b1;
      w_gnt_host = 1'b1;
    end
  end

  always_comb begin
    rom_en_d    = w_gnt_vld;
    rom_a_d     = rom_a_q;
    if (w_gnt_vld) begin
      rom_a_d   = w_gnt_host ? host_addr : dsp_addr;
    end
    tag_vld_d   = {tag_vld_q[NSTG-2:0], w_gnt_vld};
    tag_host_d  = {tag_host_q[NSTG-2:0], w_gnt_host};
    dsp_ack_d   = w_out_vld & ~w_out_host;
    host_ack_d  = w_out_vld &  w_out_host;
    dsp_data_d  = dsp_ack_d  ? w_rom_ext : dsp_data_q;
    host_data_d = host_ack_d ? w_rom_ext : host_data_q;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rr_q        <= OWN_DSP;
      rom_en_q    <= 1'b0;
      rom_a_q     <= 10'd0;
      tag_vld_q   <= '0;
      tag_host_q  <= '0;
      dsp_ack_q   <= 1'b0;
      host_ack_q  <= 1'b0;
      dsp_data_q  <= 32'd0;
      host_data_q <= 32'd0;
    end else begin
      rr_q        <= rr_d;
      rom_en_q    <= rom_en_d;
      rom_a_q     <= rom_a_d;
      tag_vld_q   <= tag_vld_d;
      tag_host_q  <= tag_host_d;
      dsp_ack_q   <= dsp_ack_d;
      host_ack_q  <= host_ack_d;
      dsp_data_q  <= dsp_data_d;
      host_data_q <= host_data_d;
    end
  end

  assign rom_en    = rom_en_q;
  assign rom_a     = rom_a_q;
  assign dsp_ack   = dsp_ack_q;
  assign dsp_data  = dsp_data_q;
  assign host_ack  = host_ack_q;
  assign host_data = host_data_q;
  assign busy      = |tag_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_j_sinerom_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_j_sinerom_arb
// Bench for j_sinerom_arb: three instances (LAT1/SIGNX1, LAT1/SIGNX0,
// LAT3/SIGNX1) driven in parallel against a cycle-count reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_j_sinerom_arb;

  logic             sys_clk = 1'b0;
  logic             reset;
  logic             dsp_req, host_req;
  logic [9:0]       dsp_addr, host_addr;
  logic [2:0]       dsp_ack_w, host_ack_w, rom_en_w, busy_w;
  logic [2:0][31:0] dsp_data_w, host_data_w;
  logic [2:0][9:0]  rom_a_w;
  logic [2:0][15:0] rom_q_w;
  logic [15:0]      mem [1024];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 sys_clk = ~sys_clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L  = (g == 2) ? 3 : 1;
      localparam bit SX = (g == 1) ? 1'b0 : 1'b1;
      logic [15:0] pipe [L];
      always @(posedge sys_clk) begin
        pipe[0] <= mem[rom_a_w[g]];
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      end
      assign rom_q_w[g] = pipe[L-1];
      j_sinerom_arb #(.ROM_LAT(L), .SIGNX(SX)) u_dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .dsp_req  (dsp_req),
        .dsp_addr (dsp_addr),
        .dsp_ack  (dsp_ack_w[g]),
        .dsp_data (dsp_data_w[g]),
        .host_req (host_req),
        .host_addr(host_addr),
        .host_ack (host_ack_w[g]),
        .host_data(host_data_w[g]),
        .rom_en   (rom_en_w[g]),
        .rom_a    (rom_a_w[g]),
        .rom_q    (rom_q_w[g]),
        .busy     (busy_w[g])
      );
    end
  endgenerate

  // Reference model: a read granted in cycle n is issued in n+1, acked in
  // n+L+2, and the owner is "in flight" from grant until its ack cycle.
  int          m_at  [3][2];
  logic [31:0] m_val [3][2];
  logic [31:0] m_dat [3][2];
  logic        m_rr  [3];
  logic        m_en  [3];
  logic [9:0]  m_a   [3];
  logic [77:0] expv  [3];
  logic [77:0] mk    [3];
  logic [77:0] obs   [3];

  always_comb begin
    for (int i = 0; i < 3; i++)
      obs[i] = {dsp_ack_w[i], host_ack_w[i], busy_w[i], rom_en_w[i],
                dsp_data_w[i], host_data_w[i], rom_a_w[i]};
  end

  always @(negedge sys_clk) begin
    logic a0, a1, e0, e1, bz;
    int gsel;
    logic [9:0]  ga;
    logic [15:0] rv;
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_at[i][0]  <= -1;
        m_at[i][1]  <= -1;
        m_dat[i][0] <= 32'd0;
        m_dat[i][1] <= 32'd0;
        m_rr[i]     <= 1'b0;
        m_en[i]     <= 1'b0;
        m_a[i]      <= 10'd0;
        expv[i]     <= '0;
        mk[i]       <= '1;
      end else begin
        a0 = (m_at[i][0] == cyc);
        a1 = (m_at[i][1] == cyc);
        bz = (m_at[i][0] > cyc) || (m_at[i][1] > cyc);
        e0 = dsp_req  && (m_at[i][0] < 0);
        e1 = host_req && (m_at[i][1] < 0);
        expv[i] <= {a0, a1, bz, m_en[i],
                    a0 ? m_val[i][0] : m_dat[i][0],
                    a1 ? m_val[i][1] : m_dat[i][1], m_a[i]};
        mk[i]   <= m_en[i] ? '1 : {{68{1'b1}}, 10'd0};
        if (a0) begin m_dat[i][0] <= m_val[i][0]; m_at[i][0] <= -1; end
        if (a1) begin m_dat[i][1] <= m_val[i][1]; m_at[i][1] <= -1; end
        gsel = -1;
        if (e0 && e1) begin
          gsel = int'(m_rr[i]);
          m_rr[i] <= ~m_rr[i];
        end else if (e0) gsel = 0;
        else if (e1) gsel = 1;
        m_en[i] <= (gsel >= 0);
        if (gsel >= 0) begin
          ga = (gsel == 1) ? host_addr : dsp_addr;
          rv = mem[ga];
          m_a[i] <= ga;
          m_at[i][gsel]  <= cyc + ((i == 2) ? 3 : 1) + 2;
          m_val[i][gsel] <= (i == 1) ? {16'h0000, rv} : {{16{rv[15]}}, rv};
        end
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1; dsp_req = 1'b0; host_req = 1'b0;
    dsp_addr = 10'd0; host_addr = 10'd0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== 78'd0) begin
        errors++;
        $display("FAIL reset_state inst%0d got=%h exp=0", i, obs[i]);
      end
    end
    @(posedge sys_clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_read;
    dsp_req = 1'b1; dsp_addr = 10'h100;
    for (int k = 0; k < 7; k++) begin
      @(negedge sys_clk); #1;
      checks++;
      if (dsp_ack_w[0] !== (k == 3)) begin
        errors++;
        $display("FAIL single_ack_l1 k=%0d got=%b exp=%b", k, dsp_ack_w[0], (k == 3));
      end
      checks++;
      if (dsp_ack_w[2] !== (k == 5)) begin
        errors++;
        $display("FAIL single_ack_l3 k=%0d got=%b exp=%b", k, dsp_ack_w[2], (k == 5));
      end
      if (k == 3) begin
        checks++;
        if (dsp_data_w[0] !== 32'h0000_7FFF) begin
          errors++;
          $display("FAIL single_data_l1 got=%h exp=00007fff", dsp_data_w[0]);
        end
      end
      if (k == 5) begin
        checks++;
        if (dsp_data_w[2] !== 32'h0000_7FFF) begin
          errors++;
          $display("FAIL single_data_l3 got=%h exp=00007fff", dsp_data_w[2]);
        end
      end
      @(posedge sys_clk); #1;
      if (k == 0) dsp_req = 1'b0;
    end
  endtask

  task automatic test_signx;
    host_req = 1'b1; host_addr = 10'h200;
    for (int k = 0; k < 7; k++) begin
      @(negedge sys_clk); #1;
      checks++;
      if (host_ack_w[0] !== (k == 3)) begin
        errors++;
        $display("FAIL signx_ack k=%0d got=%b exp=%b", k, host_ack_w[0], (k == 3));
      end
      if (k == 3) begin
        checks++;
        if (host_data_w[0] !== 32'hFFFF_8001) begin
          errors++;
          $display("FAIL signx_on got=%h exp=ffff8001", host_data_w[0]);
        end
        checks++;
        if (host_data_w[1] !== 32'h0000_8001) begin
          errors++;
          $display("FAIL signx_off got=%h exp=00008001", host_data_w[1]);
        end
        checks++;
        if (dsp_data_w[0] !== 32'h0000_7FFF) begin
          errors++;
          $display("FAIL other_hold got=%h exp=00007fff", dsp_data_w[0]);
        end
      end
      if (k == 5) begin
        checks++;
        if (host_data_w[2] !== 32'hFFFF_8001) begin
          errors++;
          $display("FAIL signx_l3 got=%h exp=ffff8001", host_data_w[2]);
        end
      end
      @(posedge sys_clk); #1;
      if (k == 0) host_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    int n_iss = 0, n_d = 0, n_h = 0, diff;
    reset = 1'b1;
    dsp_req = 1'b1; dsp_addr = 10'h155;
    host_req = 1'b1; host_addr = 10'h2AA;
    @(posedge sys_clk); #1;
    reset = 1'b0;
    for (int n = 0; n < 600 && (n_d + n_h) < 100; n++) begin
      @(negedge sys_clk); #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (((obs[i] ^ expv[i]) & mk[i]) !== 78'd0) begin
          errors++;
          $display("FAIL b2b_model inst%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expv[i]);
        end
      end
      if (rom_en_w[0]) begin
        checks++;
        if (rom_a_w[0] !== ((n_iss % 2 == 0) ? 10'h155 : 10'h2AA)) begin
          errors++;
          $display("FAIL b2b_order issue=%0d got=%h", n_iss, rom_a_w[0]);
        end
        n_iss++;
      end
      if (dsp_ack_w[0])  n_d++;
      if (host_ack_w[0]) n_h++;
      @(posedge sys_clk); #1;
    end
    diff = n_d - n_h;
    checks++;
    if ((n_d + n_h) < 100 || diff > 1 || diff < -1) begin
      errors++;
      $display("FAIL b2b_count dsp=%0d host=%0d exp total>=100 balanced", n_d, n_h);
    end
    dsp_req = 1'b0; host_req = 1'b0;
    repeat (8) @(posedge sys_clk); #1;
  endtask

  task automatic test_single_hold;
    int last = -1;
    bit seen = 1'b0;
    reset = 1'b1;
    @(posedge sys_clk); #1;
    reset = 1'b0;
    dsp_req = 1'b1; dsp_addr = 10'h0AB;
    for (int n = 0; n < 24; n++) begin
      @(negedge sys_clk); #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (((obs[i] ^ expv[i]) & mk[i]) !== 78'd0) begin
          errors++;
          $display("FAIL hold_model inst%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expv[i]);
        end
      end
      if (rom_en_w[0]) begin
        if (last >= 0) begin
          checks++;
          if (n - last !== 4) begin
            errors++;
            $display("FAIL hold_period got=%0d exp=4", n - last);
          end
        end
        last = n;
      end
      @(posedge sys_clk); #1;
    end
    dsp_req = 1'b0;
    repeat (8) @(posedge sys_clk); #1;
    dsp_req = 1'b1; dsp_addr = 10'h0CD;
    host_req = 1'b1; host_addr = 10'h0EF;
    for (int n = 0; n < 10; n++) begin
      @(negedge sys_clk); #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (((obs[i] ^ expv[i]) & mk[i]) !== 78'd0) begin
          errors++;
          $display("FAIL tie_model inst%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expv[i]);
        end
      end
      if (rom_en_w[0] && !seen) begin
        seen = 1'b1;
        checks++;
        if (rom_a_w[0] !== 10'h0CD) begin
          errors++;
          $display("FAIL first_tie got=%h exp=0cd", rom_a_w[0]);
        end
      end
      @(posedge sys_clk); #1;
      if (n == 1) begin dsp_req = 1'b0; host_req = 1'b0; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL first_tie_timeout got=no_issue exp=issue");
    end
  endtask

  task automatic test_reset_mid;
    dsp_req = 1'b1; dsp_addr = 10'h133;
    @(negedge sys_clk); #1;
    @(posedge sys_clk); #1;
    dsp_req = 1'b0;
    @(negedge sys_clk); #1;
    checks++;
    if (rom_en_w[0] !== 1'b1 || rom_a_w[0] !== 10'h133 || busy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue got en=%b a=%h busy=%b exp 1/133/1", rom_en_w[0], rom_a_w[0], busy_w[0]);
    end
    @(posedge sys_clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (busy_w !== 3'b000 || rom_en_w !== 3'b000) begin
      errors++;
      $display("FAIL mid_busy got busy=%b en=%b exp 000/000", busy_w, rom_en_w);
    end
    @(posedge sys_clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge sys_clk); #1;
      checks++;
      if (dsp_ack_w !== 3'b000) begin
        errors++;
        $display("FAIL mid_noack k=%0d got=%b exp=000", k, dsp_ack_w);
      end
      @(posedge sys_clk); #1;
    end
    dsp_req = 1'b1; dsp_addr = 10'h100;
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk); #1;
      checks++;
      if (dsp_ack_w[0] !== (k == 3) || (k == 3 && dsp_data_w[0] !== 32'h0000_7FFF)) begin
        errors++;
        $display("FAIL mid_recover k=%0d got ack=%b data=%h", k, dsp_ack_w[0], dsp_data_w[0]);
      end
      @(posedge sys_clk); #1;
      if (k == 0) dsp_req = 1'b0;
    end
    repeat (4) @(posedge sys_clk); #1;
  endtask

  task automatic test_random_lat3;
    bit d_seen = 1'b0, h_seen = 1'b0;
    int n_ack = 0;
    reset = 1'b1;
    @(posedge sys_clk); #1;
    reset = 1'b0;
    for (int n = 0; n < 800; n++) begin
      @(negedge sys_clk); #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (((obs[i] ^ expv[i]) & mk[i]) !== 78'd0) begin
          errors++;
          $display("FAIL rand_model inst%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], expv[i]);
        end
      end
      if (dsp_ack_w[2])  begin d_seen = 1'b1; n_ack++; end
      if (host_ack_w[2]) begin h_seen = 1'b1; n_ack++; end
      @(posedge sys_clk); #1;
      if (dsp_req) begin
        if (d_seen || $urandom_range(0, 19) == 0) dsp_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        dsp_req = 1'b1; dsp_addr = 10'($urandom_range(0, 1023)); d_seen = 1'b0;
      end
      if (host_req) begin
        if (h_seen || $urandom_range(0, 19) == 0) host_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        host_req = 1'b1; host_addr = 10'($urandom_range(0, 1023)); h_seen = 1'b0;
      end
    end
    checks++;
    if (n_ack < 20) begin
      errors++;
      $display("FAIL rand_activity got=%0d acks exp>=20", n_ack);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[10'h100] = 16'h7FFF;
    mem[10'h200] = 16'h8001;
    test_reset();
    test_single_read();
    test_signx();
    test_back_to_back();
    test_single_hold();
    test_reset_mid();
    test_random_lat3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
